rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Round-robin arbiter that shares one 8-input 1-bit multiplexer among eight requesters. It samples a request vector, grants exactly one requester at a time, and drives the mux's three select bits directly. Requesters are serviced fairly in rotating order. In the datapath it sits beside the shared 8:1 mux and owns its select lines, so no requester ever drives them.

## Interface
- MAX_BURST, 4: maximum consecutive cycles one owner holds the grant when the burst limit is compiled in. Legal range 1–15.
- CNT_W, 4: width of the burst counter. Must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- req  input  8  request vector; req[i] asserted means requester i wants mux input i routed.
- gnt  output  8  one-hot grant, registered; all zero when idle.
- gnt_valid  output  1  high while any grant is held; equals the OR of gnt.
- sel_2, sel_1, sel_0  output  1 each  registered binary index of the granted requester; wired to the mux selects.
- rearb  output  1  one-cycle pulse on the edge where ownership changes, including idle→grant.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: an owner is held in `owner[2:0]`.
- Rotation pointer `last[2:0]` records the most recent owner. The search order is last+1, last+2, …, last+8, all mod 8, so wrap-around from 7 to 0 is required.
- In IDLE, if req≠0, the first set bit in search order becomes owner. State goes to BUSY, `last`←owner, burst counter←1.
- In BUSY, ownership is kept while req[owner]=1 and the burst limit is not reached. The counter increments, saturating at MAX_BURST.
- Release occurs when req[owner]=0, or when the limit is reached under the macro. On release:
  - Search the other requesters in order from owner+1. If one is found it becomes the new owner: counter←1, `last` updated, rearb=1.
  - Otherwise, if req[owner]=1 (limit case, sole requester), the same owner is regranted: counter←1, rearb=0.
  - Otherwise state→IDLE: gnt←0, gnt_valid←0.
- The select bits always equal the binary index of the set gnt bit. When idle they hold their last value; sel is don't-care to the mux when gnt_valid=0.
- Reset: state=IDLE, gnt=8'h00, gnt_valid=0, {sel_2,sel_1,sel_0}=3'b000, rearb=0, last=3'd7, counter=0. With last=7, the first search after reset starts at index 0.
- Reset asserted mid-grant drops the grant on that edge. The next arbitration starts at index 0.
- Requests arriving while another owner holds the grant are queued implicitly and honoured in rotation order. No request is ever skipped twice in a row.

## Timing
- Grant latency: req sampled at edge N drives gnt/sel/gnt_valid after edge N, so one cycle from request to grant.
- Release latency: req[owner] falling before edge N frees the grant at edge N. The next owner's gnt is valid in the same cycle, with no idle bubble.
- Handshake: a requester keeps req high until it sees its gnt bit, then drops req to release. Dropping req before the grant withdraws the request without penalty.
- Simultaneous requests on the same edge resolve purely by rotation order, never by fixed index priority.
- The rearb pulse is registered and aligned with the new gnt value.
- All outputs are registered; there is no combinational path from req to any output.

## Configuration
- ARB_BURST_LIMIT_EN, defined: an owner is forced to release after MAX_BURST consecutive granted cycles whenever another requester is waiting. If no one else is waiting, the owner is silently regranted and its counter restarts.
- ARB_BURST_LIMIT_EN, undefined: an owner holds the grant until it deasserts req. The counter logic is absent and MAX_BURST and CNT_W are ignored.

## Test plan
- Reset, then req=8'h01 for 3 cycles. Expect gnt=8'h01, sel=000, gnt_valid=1 one cycle later, rearb pulse once. After req→0, expect gnt=8'h00 next cycle.
- req=8'hFF held, each owner dropping req one cycle after its grant. Expect grant order 0,1,2,…,7, then 0 again (wrap-around), and sel matching each index.
- Owner 5 held, req={5,2} both high, then req[5] dropped. Expect gnt=8'h04, sel=010 on the next edge, no idle cycle, rearb=1.
- Macro defined, MAX_BURST=4, req=8'h09 held constantly. Expect owner 0 for 4 cycles, owner 3 for 4 cycles, then owner 0, repeating. With the macro undefined, expect owner 0 indefinitely.
- Macro defined, req=8'h10 alone held for 10 cycles. Expect gnt=8'h10 continuously with rearb low after the first grant.
- Assert reset while owner 6 is granted. Expect gnt=8'h00, sel=000, gnt_valid=0 the next cycle. Then req=8'h41 gives owner 0 first.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter owning the select lines of a shared 8:1 mux.
// Grants one requester at a time, rotating the search start past the most
// recent owner.
// Optional feature macro: ARB_BURST_LIMIT_EN. When it is defined, an owner is
// forced off after MAX_BURST consecutive cycles if someone else is waiting.
//
// Request/grant handshake: a requester raises req[i] and keeps it high until
// it sees gnt[i]. It holds req[i] for as long as it needs the mux, then drops
// req[i] to release. Dropping req[i] before the grant withdraws the request.
// Every output is registered, so there is no combinational path from req to
// any output.
module rr_arbiter_8 #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       sel_2,
  output logic       sel_1,
  output logic       sel_0,
  output logic       rearb,
  output logic       dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // Reject burst settings the counter cannot represent.
  if (MAX_BURST < 1 || MAX_BURST > 15 || (1 << CNT_W) <= MAX_BURST) begin : g_bad_cfg
    $error("rr_arbiter_8: illegal MAX_BURST/CNT_W combination");
  end

  state_e     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] last_q,  last_d;
  logic [7:0] gnt_q,   gnt_d;
  logic       rearb_q, rearb_d;

  logic [2:0] base;
  logic [2:0] cand;
  logic       found;
  logic [2:0] found_idx;
  logic       limit_hit;
  logic       release_own;

`ifdef ARB_BURST_LIMIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign limit_hit = (cnt_q == CNT_W'(MAX_BURST));
`else
  assign limit_hit = 1'b0;
`endif

  // While busy, last equals owner. The search excludes the current owner, so a
  // release always prefers someone else.
  assign base        = (state_q == S_BUSY) ? owner_q : last_q;
  assign release_own = !req[owner_q] || limit_hit;

  // Find the first requester in rotation order, starting just after base.
  always_comb begin
    found     = 1'b0;
    found_idx = 3'd0;
    cand      = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = base + k[2:0];
      if (!found && req[cand] && !(state_q == S_BUSY && cand == owner_q)) begin
        found     = 1'b1;
        found_idx = cand;
      end
    end
  end

  // Next-state, grant and re-arbitration pulse decisions.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    rearb_d = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_BUSY;
          owner_d = found_idx;
          last_d  = found_idx;
          gnt_d   = 8'd1 << found_idx;
          rearb_d = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
          cnt_d   = CNT_W'(1);
`endif
        end
      end
      S_BUSY: begin
        if (release_own) begin
          if (found) begin
            owner_d = found_idx;
            last_d  = found_idx;
            gnt_d   = 8'd1 << found_idx;
            rearb_d = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
            cnt_d   = CNT_W'(1);
`endif
          end else if (req[owner_q]) begin
            // Limit reached with nobody else waiting: quietly regrant.
`ifdef ARB_BURST_LIMIT_EN
            cnt_d   = CNT_W'(1);
`endif
          end else begin
            state_d = S_IDLE;
            gnt_d   = 8'h00;
          end
        end else begin
`ifdef ARB_BURST_LIMIT_EN
          if (cnt_q < CNT_W'(MAX_BURST)) cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 8'h00;
      end
    endcase
  end

  // State registers. last resets to 7 so the first search starts at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 3'd0;
      last_q  <= 3'd7;
      gnt_q   <= 8'h00;
      rearb_q <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      rearb_q <= rearb_d;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign sel_2     = owner_q[2];
  assign sel_1     = owner_q[1];
  assign sel_0     = owner_q[0];
  assign rearb     = rearb_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed bench for rr_arbiter_8 with hand-computed
// expectations for both builds of ARB_BURST_LIMIT_EN.
module tb_rr_arbiter_8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       sel_2, sel_1, sel_0;
  logic       rearb;
  logic       dbg_state;

  int checks   = 0;
  int failures = 0;

  rr_arbiter_8 #(.MAX_BURST(4), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .sel_2     (sel_2),
    .sel_1     (sel_1),
    .sel_0     (sel_0),
    .rearb     (rearb),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against one expected grant picture.
  task automatic check_all(input string tag, input logic [7:0] eg, input logic [2:0] esel,
                           input logic ev, input logic er);
    check({tag, ".gnt"},   gnt, eg);
    check({tag, ".sel"},   {5'd0, sel_2, sel_1, sel_0}, {5'd0, esel});
    check({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, ev});
    check({tag, ".rearb"}, {7'd0, rearb}, {7'd0, er});
    check({tag, ".state"}, {7'd0, dbg_state}, {7'd0, ev});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 8'h00;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] eg;
    logic       er;
    int         cur;

    reset = 1'b1;
    req   = 8'h00;

    // Reset state.
    do_reset();
    check_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // Single requester 0 for three cycles, then release.
    req = 8'h01;
    step(); check_all("t1_grant", 8'h01, 3'd0, 1'b1, 1'b1);
    step(); check_all("t1_hold1", 8'h01, 3'd0, 1'b1, 1'b0);
    step(); check_all("t1_hold2", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step(); check_all("t1_release", 8'h00, 3'd0, 1'b0, 1'b0);

    // All requesting; each owner drops out right after its grant.
    do_reset();
    req = 8'hFF;
    step(); check_all("t2_first", 8'h01, 3'd0, 1'b1, 1'b1);
    cur = 0;
    for (int i = 0; i < 8; i++) begin
      req = ~(8'd1 << cur);
      step();
      cur = (cur + 1) % 8;
      check_all($sformatf("t2_rot%0d", cur), 8'd1 << cur, cur[2:0], 1'b1, 1'b1);
    end

    // Owner 5 hands over to waiting requester 2 without a bubble.
    req = 8'h00;
    step(); check_all("t3_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h20;
    step(); check_all("t3_own5", 8'h20, 3'd5, 1'b1, 1'b1);
    req = 8'h24;
    step(); check_all("t3_hold5", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h04;
    step(); check_all("t3_hand2", 8'h04, 3'd2, 1'b1, 1'b1);

    // Requesters 0 and 3 held constantly.
    do_reset();
    req = 8'h09;
    for (int s = 0; s < 9; s++) begin
      step();
`ifdef ARB_BURST_LIMIT_EN
      eg = (((s / 4) % 2) == 0) ? 8'h01 : 8'h08;
      er = ((s % 4) == 0);
`else
      eg = 8'h01;
      er = (s == 0);
`endif
      check_all($sformatf("t4_s%0d", s), eg, (eg == 8'h08) ? 3'd3 : 3'd0, 1'b1, er);
    end

    // Sole requester 4 held for ten cycles: continuous grant, no repeat pulse.
    req = 8'h00;
    step(); check_all("t5_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h10;
    for (int s = 0; s < 10; s++) begin
      step();
      check_all($sformatf("t5_s%0d", s), 8'h10, 3'd4, 1'b1, (s == 0));
    end

    // Reset mid-grant drops the grant; next arbitration starts at index 0.
    req = 8'h00;
    step(); check_all("t6_idle", 8'h00, 3'd4, 1'b0, 1'b0);
    req = 8'h40;
    step(); check_all("t6_own6", 8'h40, 3'd6, 1'b1, 1'b1);
    reset = 1'b1;
    step(); check_all("t6_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    req = 8'h41;
    step(); check_all("t6_after", 8'h01, 3'd0, 1'b1, 1'b1);
    req = 8'h40;
    step(); check_all("t6_next6", 8'h40, 3'd6, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
